regfile_wb_arbiter: RTL

- Shares the register-file write port between two writeback sources: ALU result (src A) and memory load (src M).
- Each cycle, grants at most one source, round-robin when both request.
- Decodes the granted 4-bit destination register into a registered one-hot 16-bit write-enable.
- Sits between the execute/memory stages and the register file. It replaces the bare 4-to-16 decoder on the write path.

---
 rtl/regfile_wb_arbiter.sv | 84 ++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter for the register-file write port (ALU vs load).
// The granted destination is decoded into a registered one-hot write enable. Revision 1.0.
`default_nettype none

module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  localparam int NREG  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              m_valid,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              m_ready,
  input  logic              hold,
  output logic [NREG-1:0]   we,
  output logic [DATA_W-1:0] wdata,
  output logic              pc_wr,
  output logic              last_m
);

  localparam logic [ADDR_W-1:0] C_PC_ADDR = ADDR_W'(NREG - 1);

  logic [NREG-1:0]   we_q,    we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              pc_wr_q, pc_wr_d;
  logic              last_m_q, last_m_d;

  logic              w_a_ready;
  logic              w_m_ready;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;

  // M wins a tie when A was served last (last_m=0), so the sources alternate.
  assign w_a_ready = rst_n && !hold && a_valid && (!m_valid || last_m_q);
  assign w_m_ready = rst_n && !hold && m_valid && (!a_valid || !last_m_q);
  assign w_xfer    = w_a_ready || w_m_ready;

  assign w_sel_addr = w_m_ready ? m_addr : a_addr;
  assign w_sel_data = w_m_ready ? m_data : a_data;

  always_comb begin
    we_d     = '0;
    pc_wr_d  = 1'b0;
    wdata_d  = wdata_q;
    last_m_d = last_m_q;
    if (w_xfer) begin
      we_d     = NREG'(1) << w_sel_addr;
      pc_wr_d  = (w_sel_addr == C_PC_ADDR);
      wdata_d  = w_sel_data;
      last_m_d = w_m_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= '0;
      wdata_q  <= '0;
      pc_wr_q  <= 1'b0;
      last_m_q <= 1'b0;
    end else begin
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      pc_wr_q  <= pc_wr_d;
      last_m_q <= last_m_d;
    end
  end

  assign a_ready = w_a_ready;
  assign m_ready = w_m_ready;
  assign we      = we_q;
  assign wdata   = wdata_q;
  assign pc_wr   = pc_wr_q;
  assign last_m  = last_m_q;

endmodule

`default_nettype wire
